// File: rtl/window_pattern_gen_if.sv
// Configuration inputs and raster/pixel outputs of window_pattern_gen.
// The master drives the configuration and the slave (the generator) drives the video.
interface window_pattern_gen_if #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 12
);
  logic                 enable;
  logic [1:0]           mode;
  logic [3*DSIZE-1:0]   solid_color;
  logic [CSIZE-1:0]     top;
  logic [CSIZE-1:0]     left;
  logic [CSIZE-1:0]     width;
  logic [CSIZE-1:0]     height;

  logic                 vs;
  logic                 hs;
  logic                 de_full;
  logic                 de;
  logic [3*DSIZE-1:0]   data;
  logic [15:0]          hactive;
  logic [15:0]          vactive;

  modport master (
    output enable, mode, solid_color, top, left, width, height,
    input  vs, hs, de_full, de, data, hactive, vactive
  );

  modport slave (
    input  enable, mode, solid_color, top, left, width, height,
    output vs, hs, de_full, de, data, hactive, vactive
  );
endinterface

// File: rtl/window_pattern_gen.sv
// Raster timing generator with a clipped sub-window carrying one of four test patterns.
// Window configuration is shadowed on the last pixel of each frame (and while idle).
module window_pattern_gen #(
  parameter int DSIZE     = 8,
  parameter int CSIZE     = 12,
  parameter int H_ACTIVE  = 1920,
  parameter int H_FP      = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter int CELL_LOG2 = 4
) (
  input  logic                pclk,
  input  logic                prst,
  window_pattern_gen_if.slave vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = (HW > VW) ? HW : VW;
  localparam int AW      = ((CSIZE > CW) ? CSIZE : CW) + 2;
  localparam int PW      = 3 * DSIZE;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_e;

  // Raster position and frame counter.
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  // Shadowed configuration; width/height are kept only in clipped form.
  mode_e            mode_q, mode_d;
  logic [PW-1:0]    solid_q, solid_d;
  logic [CSIZE-1:0] left_q, left_d;
  logic [CSIZE-1:0] top_q, top_d;
  logic [CSIZE-1:0] ew_q, ew_d;
  logic [CSIZE-1:0] eh_q, eh_d;

  // Colour-bar position of the pixel currently addressed by the counters.
  logic [CSIZE-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]       bar_idx_q, bar_idx_d;

  // Registered outputs.
  logic             vs_q, vs_d;
  logic             hs_q, hs_d;
  logic             de_full_q, de_full_d;
  logic             de_q, de_d;
  logic [PW-1:0]    data_q, data_d;
  logic [15:0]      hactive_q, hactive_d;
  logic [15:0]      vactive_q, vactive_d;

  // Decode of the current counter state.
  logic             last_pix;
  logic             shadow_load;
  logic [AW-1:0]    x_a, y_a, xr_a, yr_a;
  logic             de_full_c, hs_c, vs_c, in_win;
  logic [CSIZE-1:0] bar_w;
  logic [CSIZE:0]   ck_sum;
  logic             ck_cell;
  logic [PW-1:0]    pix_c;

  function automatic logic [CSIZE-1:0] clip_len(input logic [CSIZE-1:0] org,
                                                input logic [CSIZE-1:0] size,
                                                input int               active);
    logic [AW-1:0] rem;
    rem = AW'(active) - AW'(org);
    if (AW'(org) >= AW'(active)) return '0;
    if (AW'(size) < rem)         return size;
    return CSIZE'(rem);
  endfunction

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [PW-1:0] bar_color(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return {{DSIZE{rgb[2]}}, {DSIZE{rgb[1]}}, {DSIZE{rgb[0]}}};
  endfunction

  // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    last_pix    = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    shadow_load = !vid.enable || last_pix;

    hcnt_d = '0;
    vcnt_d = '0;
    if (vid.enable) begin
      if (hcnt_q == H_LAST) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
      end
    end

    frame_cnt_d = (vid.enable && last_pix) ? frame_cnt_q + 8'd1 : frame_cnt_q;

    mode_d  = mode_q;
    solid_d = solid_q;
    left_d  = left_q;
    top_d   = top_q;
    ew_d    = ew_q;
    eh_d    = eh_q;
    if (shadow_load) begin
      mode_d  = mode_e'(vid.mode);
      solid_d = vid.solid_color;
      left_d  = vid.left;
      top_d   = vid.top;
      ew_d    = clip_len(vid.left, vid.width, H_ACTIVE);
      eh_d    = clip_len(vid.top, vid.height, V_ACTIVE);
    end
  end

  always_comb begin
    x_a = AW'(hcnt_q);
    y_a = AW'(vcnt_q);

    de_full_c = (x_a < AW'(H_ACTIVE)) && (y_a < AW'(V_ACTIVE));
    hs_c      = (x_a >= AW'(H_ACTIVE + H_FP)) && (x_a < AW'(H_ACTIVE + H_FP + H_SYNC));
    vs_c      = (y_a >= AW'(V_ACTIVE + V_FP)) && (y_a < AW'(V_ACTIVE + V_FP + V_SYNC));
    in_win    = de_full_c
             && (x_a >= AW'(left_q)) && (x_a < AW'(left_q) + AW'(ew_q))
             && (y_a >= AW'(top_q))  && (y_a < AW'(top_q) + AW'(eh_q));

    xr_a = x_a - AW'(left_q);
    yr_a = y_a - AW'(top_q);

    bar_w   = ((ew_q >> 3) == '0) ? CSIZE'(1) : (ew_q >> 3);
    ck_sum  = (CSIZE + 1)'(xr_a) + (CSIZE + 1)'(frame_cnt_q);
    ck_cell = ck_sum[CELL_LOG2] ^ yr_a[CELL_LOG2];

    case (mode_q)
      MODE_SOLID: pix_c = solid_q;
      MODE_RAMP:  pix_c = {3{DSIZE'(xr_a)}};
      MODE_BARS:  pix_c = bar_color(bar_idx_q);
      default:    pix_c = ck_cell ? {PW{1'b1}} : '0;
    endcase

    // Bar position restarts outside the window, i.e. at the start of every window line.
    bar_pix_d = '0;
    bar_idx_d = '0;
    if (vid.enable && in_win) begin
      if (bar_pix_q == bar_w - CSIZE'(1)) begin
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + CSIZE'(1);
        bar_idx_d = bar_idx_q;
      end
    end
  end

  always_comb begin
    vs_d      = 1'b0;
    hs_d      = 1'b0;
    de_full_d = 1'b0;
    de_d      = 1'b0;
    data_d    = '0;
    hactive_d = '0;
    vactive_d = '0;
    if (vid.enable) begin
      vs_d      = vs_c;
      hs_d      = hs_c;
      de_full_d = de_full_c;
      de_d      = in_win;
      data_d    = in_win ? pix_c : '0;
      hactive_d = 16'(ew_q);
      vactive_d = 16'(eh_q);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (prst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      frame_cnt_q <= '0;
      mode_q      <= MODE_SOLID;
      solid_q     <= '0;
      left_q      <= '0;
      top_q       <= '0;
      ew_q        <= '0;
      eh_q        <= '0;
      bar_pix_q   <= '0;
      bar_idx_q   <= '0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      de_full_q   <= 1'b0;
      de_q        <= 1'b0;
      data_q      <= '0;
      hactive_q   <= '0;
      vactive_q   <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      solid_q     <= solid_d;
      left_q      <= left_d;
      top_q       <= top_d;
      ew_q        <= ew_d;
      eh_q        <= eh_d;
      bar_pix_q   <= bar_pix_d;
      bar_idx_q   <= bar_idx_d;
      vs_q        <= vs_d;
      hs_q        <= hs_d;
      de_full_q   <= de_full_d;
      de_q        <= de_d;
      data_q      <= data_d;
      hactive_q   <= hactive_d;
      vactive_q   <= vactive_d;
    end
  end

  assign vid.vs      = vs_q;
  assign vid.hs      = hs_q;
  assign vid.de_full = de_full_q;
  assign vid.de      = de_q;
  assign vid.data    = data_q;
  assign vid.hactive = hactive_q;
  assign vid.vactive = vactive_q;

endmodule

// File: tb/tb_window_pattern_gen.sv
// Scoreboard bench for window_pattern_gen on a 22x11 raster: a pixel-rule model
// queues the expected output of every clock and a monitor compares it on the falling edge.
module tb_window_pattern_gen;

  localparam int DSIZE     = 8;
  localparam int CSIZE     = 12;
  localparam int H_ACT     = 16;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 2;
  localparam int H_BP      = 2;
  localparam int V_ACT     = 8;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 1;
  localparam int V_BP      = 1;
  localparam int CELL_LOG2 = 1;
  localparam int H_TOT     = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME     = H_TOT * V_TOT;
  localparam int CELL      = 1 << CELL_LOG2;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de_full;
    logic        de;
    logic [23:0] data;
    logic [15:0] hactive;
    logic [15:0] vactive;
  } out_t;

  logic clk  = 1'b0;
  logic prst = 1'b1;
  always #5 clk = ~clk;

  window_pattern_gen_if #(.DSIZE(DSIZE), .CSIZE(CSIZE)) bus ();

  window_pattern_gen #(
    .DSIZE(DSIZE), .CSIZE(CSIZE),
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CELL_LOG2(CELL_LOG2)
  ) dut (
    .pclk(clk),
    .prst(prst),
    .vid (bus)
  );

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];

  // Reference state: raster position, frame count and the frame's latched configuration.
  int          m_h = 0, m_v = 0, m_fc = 0;
  int          sh_mode = 0, sh_left = 0, sh_top = 0, sh_ew = 0, sh_eh = 0;
  logic [23:0] sh_solid = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip_len(input int org, input int size, input int active);
    if (org >= active) return 0;
    return (size < active - org) ? size : active - org;
  endfunction

  task automatic model_latch();
    sh_mode  = int'(bus.mode);
    sh_solid = bus.solid_color;
    sh_left  = int'(bus.left);
    sh_top   = int'(bus.top);
    sh_ew    = clip_len(int'(bus.left), int'(bus.width), H_ACT);
    sh_eh    = clip_len(int'(bus.top), int'(bus.height), V_ACT);
  endtask

  function automatic out_t model_pix(input int h, input int v);
    out_t o;
    int   xr, yr, bw, idx;
    o         = '0;
    xr        = h - sh_left;
    yr        = v - sh_top;
    o.de_full = (h < H_ACT) && (v < V_ACT);
    o.hs      = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC);
    o.vs      = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC);
    o.de      = o.de_full && (xr >= 0) && (xr < sh_ew) && (yr >= 0) && (yr < sh_eh);
    o.hactive = 16'(sh_ew);
    o.vactive = 16'(sh_eh);
    if (o.de) begin
      case (sh_mode)
        0: o.data = sh_solid;
        1: o.data = {3{8'(xr)}};
        2: begin
          bw  = (sh_ew / 8 > 0) ? sh_ew / 8 : 1;
          idx = xr / bw;
          if (idx > 7) idx = 7;
          o.data = BARS[idx];
        end
        default: o.data = ((((xr + m_fc) / CELL) ^ (yr / CELL)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
      endcase
    end
    return o;
  endfunction

  // Reference model: one expected output word per rising edge.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      if (prst) begin
        e = '0;
        m_h = 0; m_v = 0; m_fc = 0;
        sh_mode = 0; sh_left = 0; sh_top = 0; sh_ew = 0; sh_eh = 0; sh_solid = '0;
      end else if (!bus.enable) begin
        e = '0;
        m_h = 0; m_v = 0;
        model_latch();
      end else begin
        e = model_pix(m_h, m_v);
        if (m_h == H_TOT - 1 && m_v == V_TOT - 1) begin
          model_latch();
          m_fc = (m_fc + 1) % 256;
        end
        if (m_h == H_TOT - 1) begin
          m_h = 0;
          m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
        end else begin
          m_h++;
        end
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every registered output word away from the rising edge.
  initial begin
    out_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.vs, bus.hs, bus.de_full, bus.de, bus.data, bus.hactive, bus.vactive};
        check("pixel", a, e);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_win(input int mode, input int l, input int t, input int w, input int h);
    bus.mode   = 2'(mode);
    bus.left   = CSIZE'(l);
    bus.top    = CSIZE'(t);
    bus.width  = CSIZE'(w);
    bus.height = CSIZE'(h);
  endtask

  // Any FRAME consecutive cycles of a steady configuration hold exactly one frame's worth.
  task automatic count_frame(input string tag, input int exp_de, input int exp_full,
                             input int exp_hs, input int exp_vs);
    int n_de = 0, n_full = 0, n_hs = 0, n_vs = 0;
    repeat (FRAME) begin
      @(negedge clk);
      n_de   += int'(bus.de);
      n_full += int'(bus.de_full);
      n_hs   += int'(bus.hs);
      n_vs   += int'(bus.vs);
    end
    check({tag, "_de_count"},      64'(n_de),   64'(exp_de));
    check({tag, "_de_full_count"}, 64'(n_full), 64'(exp_full));
    check({tag, "_hs_count"},      64'(n_hs),   64'(exp_hs));
    check({tag, "_vs_count"},      64'(n_vs),   64'(exp_vs));
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.solid_color = '0;
    set_win(0, 0, 0, 0, 0);
    prst = 1'b1;
    tick(3);
    check("reset_outputs",
          {bus.vs, bus.hs, bus.de_full, bus.de, bus.data, bus.hactive, bus.vactive}, 64'd0);
    prst = 1'b0;

    // Ramp window configured while idle, then three full frames.
    set_win(1, 4, 2, 5, 3);
    tick(2);
    bus.enable = 1'b1;
    tick(3 * FRAME);
    count_frame("ramp", 15, H_ACT * V_ACT, H_SYNC * V_TOT, H_TOT * V_SYNC);
    check("ramp_hactive", 64'(bus.hactive), 64'd5);
    check("ramp_vactive", 64'(bus.vactive), 64'd3);

    // Mid-frame changes: right-edge clipping, then a window fully off-screen.
    tick(37);
    set_win(1, 12, 2, 10, 3);
    tick(2 * FRAME);
    count_frame("clip", 12, H_ACT * V_ACT, H_SYNC * V_TOT, H_TOT * V_SYNC);
    check("clip_hactive", 64'(bus.hactive), 64'd4);
    set_win(1, 20, 2, 10, 3);
    tick(2 * FRAME);
    count_frame("offscreen", 0, H_ACT * V_ACT, H_SYNC * V_TOT, H_TOT * V_SYNC);
    check("offscreen_hactive", 64'(bus.hactive), 64'd0);

    // Full-width colour bars.
    set_win(2, 0, 0, 16, 8);
    tick(2 * FRAME);
    count_frame("bars", 128, H_ACT * V_ACT, H_SYNC * V_TOT, H_TOT * V_SYNC);

    // Randomised configuration changes with occasional idle gaps.
    repeat (40) begin
      tick(int'($urandom_range(20, 300)));
      bus.solid_color = 24'($urandom);
      set_win(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 10)));
      if ($urandom_range(0, 3) == 0) begin
        bus.enable = 1'b0;
        tick(int'($urandom_range(1, 6)));
        bus.enable = 1'b1;
      end
    end

    // Reset pulse sampled with the counters at pixel (7,3).
    begin
      int found = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
        if (m_h == 7 && m_v == 3) begin
          found = 1;
          break;
        end
        tick(1);
      end
      check("reset_point_reached", 64'(found), 64'd1);
    end
    prst = 1'b1;
    tick(1);
    check("midframe_reset_outputs",
          {bus.vs, bus.hs, bus.de_full, bus.de, bus.data, bus.hactive, bus.vactive}, 64'd0);
    prst = 1'b0;
    set_win(1, 4, 2, 5, 3);
    tick(FRAME + 50);

    // Enable held low for five cycles mid-frame.
    bus.enable = 1'b0;
    tick(5);
    check("idle_outputs",
          {bus.vs, bus.hs, bus.de_full, bus.de, bus.data, bus.hactive, bus.vactive}, 64'd0);
    bus.enable = 1'b1;
    tick(FRAME);

    // Moving checkerboard across more than 256 frames so the frame counter wraps.
    set_win(3, 0, 0, 16, 8);
    tick(258 * FRAME);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
